// File: rtl/tx_fire_ctrl.sv
// Transmit burst controller: fires a delayed bipolar pulse burst per channel,
// then pulses done/rx_start once every channel's burst has finished.
module tx_fire_ctrl #(
  parameter int NUM_CH  = 4,
  parameter int DELAY_W = 8,
  parameter int HP_W    = 4,
  parameter int CYC_W   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_CH*DELAY_W-1:0]   delay_flat,
  input  logic [HP_W-1:0]             half_period,
  input  logic [CYC_W-1:0]            num_cycles,
  output logic [NUM_CH-1:0]           tx_p,
  output logic [NUM_CH-1:0]           tx_n,
  output logic [NUM_CH-1:0]           tx_en,
  output logic                        busy,
  output logic                        done,
  output logic                        rx_start,
  output logic [1:0]                  debug_state
);

  localparam int T_W = DELAY_W + HP_W + CYC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  logic [NUM_CH*DELAY_W-1:0]  r_delay;
  logic [HP_W-1:0]            r_hp;
  logic [T_W-1:0]             r_burst;
  logic [T_W-1:0]             r_t;
  logic [T_W-1:0]             r_last;
  logic [HP_W-1:0]            r_ph [NUM_CH];
  logic [NUM_CH-1:0]          r_tx_p;
  logic [NUM_CH-1:0]          r_tx_n;
  logic [NUM_CH-1:0]          r_tx_en;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_rx_start;

  logic                       w_launch;
  logic                       w_fire_next;
  logic [HP_W-1:0]            w_hp_in;
  logic [HP_W-1:0]            w_hp_sel;
  logic [T_W-1:0]             w_burst_in;
  logic [T_W-1:0]             w_burst_sel;
  logic [NUM_CH*DELAY_W-1:0]  w_delay_sel;
  logic [T_W-1:0]             w_t_next;
  logic [DELAY_W-1:0]         w_max_d;
  logic [NUM_CH-1:0]          w_p_next;
  logic [NUM_CH-1:0]          w_n_next;
  logic [HP_W-1:0]            w_ph_next [NUM_CH];

  // Outputs are registered, so each edge computes the waveform for the
  // upcoming value of t; on the launch edge that uses the live inputs.
  assign w_launch    = (r_state == S_IDLE) && start;
  assign w_hp_in     = (half_period == '0) ? HP_W'(1) : half_period;
  assign w_burst_in  = T_W'({w_hp_in, 1'b0}) * T_W'(num_cycles);
  assign w_hp_sel    = w_launch ? w_hp_in    : r_hp;
  assign w_burst_sel = w_launch ? w_burst_in : r_burst;
  assign w_delay_sel = w_launch ? delay_flat : r_delay;
  assign w_t_next    = w_launch ? '0 : r_t + T_W'(1);
  assign w_fire_next = (w_launch && (num_cycles != '0)) ||
                       ((r_state == S_FIRE) && (r_t != r_last));

  always_comb begin
    w_max_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (delay_flat[i*DELAY_W +: DELAY_W] > w_max_d)
        w_max_d = delay_flat[i*DELAY_W +: DELAY_W];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [T_W-1:0] w_d_ext;
      logic           w_in_win;
      logic           w_first;
      logic           w_toggle;

      assign w_d_ext  = T_W'(w_delay_sel[gi*DELAY_W +: DELAY_W]);
      assign w_in_win = w_fire_next && (w_t_next >= w_d_ext) &&
                        (w_t_next < w_d_ext + w_burst_sel);
      assign w_first  = (w_t_next == w_d_ext);
      // r_ph counts cycles already spent in the current half period.
      assign w_toggle = (r_ph[gi] == w_hp_sel);

      assign w_p_next[gi]  = w_in_win & (w_first | (w_toggle ? r_tx_n[gi] : r_tx_p[gi]));
      assign w_n_next[gi]  = w_in_win & ~w_first & (w_toggle ? r_tx_p[gi] : r_tx_n[gi]);
      assign w_ph_next[gi] = !w_in_win ? '0 :
                             (w_first || w_toggle) ? HP_W'(1) : r_ph[gi] + HP_W'(1);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_delay    <= '0;
      r_hp       <= '0;
      r_burst    <= '0;
      r_t        <= '0;
      r_last     <= '0;
      r_tx_p     <= '0;
      r_tx_n     <= '0;
      r_tx_en    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_ph[i] <= '0;
    end else begin
      r_tx_p     <= w_p_next;
      r_tx_n     <= w_n_next;
      r_tx_en    <= w_p_next | w_n_next;
      r_done     <= 1'b0;
      r_rx_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_ph[i] <= w_ph_next[i];

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_delay <= delay_flat;
            r_hp    <= w_hp_in;
            r_burst <= w_burst_in;
            r_t     <= '0;
            r_last  <= T_W'(w_max_d) + w_burst_in - T_W'(1);
            r_busy  <= 1'b1;
            if (num_cycles == '0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_rx_start <= 1'b1;
            end else begin
              r_state <= S_FIRE;
            end
          end
        end
        S_FIRE: begin
          r_t <= r_t + T_W'(1);
          if (r_t == r_last) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_rx_start <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_p        = r_tx_p;
  assign tx_n        = r_tx_n;
  assign tx_en       = r_tx_en;
  assign busy        = r_busy;
  assign done        = r_done;
  assign rx_start    = r_rx_start;
  assign debug_state = r_state;

endmodule

// File: tb/tb_tx_fire_ctrl.sv
// Directed bench for tx_fire_ctrl: cycle tables of expected pulser outputs per shot.
module tb_tx_fire_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] delay_flat;
  logic [3:0]  half_period;
  logic [3:0]  num_cycles;
  logic [3:0]  tx_p, tx_n, tx_en;
  logic        busy, done, rx_start;
  logic [1:0]  debug_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] e_p    [32];
  logic [3:0] e_n    [32];
  logic       e_done [32];
  logic       e_busy [32];
  logic [1:0] e_st   [32];

  tx_fire_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .delay_flat(delay_flat),
    .half_period(half_period), .num_cycles(num_cycles),
    .tx_p(tx_p), .tx_n(tx_n), .tx_en(tx_en), .busy(busy), .done(done),
    .rx_start(rx_start), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Invariants hold in every cycle of every test.
  always @(negedge clk) begin
    check("excl", 32'(tx_p & tx_n), 32'd0);
    check("en_or", 32'(tx_en), 32'(tx_p | tx_n));
  end

  task automatic set_row(input int i, input logic [3:0] p, input logic [3:0] n,
                         input logic d, input logic b, input logic [1:0] st);
    e_p[i] = p; e_n[i] = n; e_done[i] = d; e_busy[i] = b; e_st[i] = st;
  endtask

  // Called at a negedge with parameters set; row 0 is the cycle after the start edge.
  task automatic run_table(input string tag, input int len, input int dis_at,
                           input logic [31:0] alt_delay);
    start = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      check($sformatf("%s_p%0d", tag, i), 32'(tx_p), 32'(e_p[i]));
      check($sformatf("%s_n%0d", tag, i), 32'(tx_n), 32'(e_n[i]));
      check($sformatf("%s_done%0d", tag, i), 32'(done), 32'(e_done[i]));
      check($sformatf("%s_rxs%0d", tag, i), 32'(rx_start), 32'(e_done[i]));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(e_busy[i]));
      check($sformatf("%s_st%0d", tag, i), 32'(debug_state), 32'(e_st[i]));
      if (i == dis_at) begin
        delay_flat = alt_delay;
        start = 1'b1;
      end else if (i == dis_at + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic load_staggered;
    set_row(0, 4'h1, 4'h0, 0, 1, 1); set_row(1, 4'h1, 4'h0, 0, 1, 1);
    set_row(2, 4'h2, 4'h1, 0, 1, 1); set_row(3, 4'h2, 4'h1, 0, 1, 1);
    set_row(4, 4'h4, 4'h2, 0, 1, 1); set_row(5, 4'h4, 4'h2, 0, 1, 1);
    set_row(6, 4'h8, 4'h4, 0, 1, 1); set_row(7, 4'h8, 4'h4, 0, 1, 1);
    set_row(8, 4'h0, 4'h8, 0, 1, 1); set_row(9, 4'h0, 4'h8, 0, 1, 1);
    set_row(10, 4'h0, 4'h0, 1, 1, 2); set_row(11, 4'h0, 4'h0, 0, 0, 0);
  endtask

  initial begin
    int done_idx, cnt_p, cnt_n, cnt_part, cnt_done;
    reset = 1'b1; start = 1'b0; delay_flat = '0; half_period = '0; num_cycles = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'({tx_p, tx_n, tx_en}), 32'd0);
    check("rst_ctl", 32'({busy, done, rx_start}), 32'd0);
    check("rst_st", 32'(debug_state), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Staggered delays, hp=2, one cycle.
    delay_flat = {8'd6, 8'd4, 8'd2, 8'd0}; half_period = 4'd2; num_cycles = 4'd1;
    load_staggered();
    run_table("stag", 12, -1, '0);
    $display("[TB] staggered shot done");

    // num_cycles=0: straight to DONE.
    num_cycles = 4'd0;
    set_row(0, 4'h0, 4'h0, 1, 1, 2); set_row(1, 4'h0, 4'h0, 0, 0, 0);
    run_table("nc0", 2, -1, '0);
    $display("[TB] zero-cycle shot done");

    // hp=0 behaves as hp=1, two cycles, all delays zero.
    delay_flat = '0; half_period = 4'd0; num_cycles = 4'd2;
    set_row(0, 4'hF, 4'h0, 0, 1, 1); set_row(1, 4'h0, 4'hF, 0, 1, 1);
    set_row(2, 4'hF, 4'h0, 0, 1, 1); set_row(3, 4'h0, 4'hF, 0, 1, 1);
    set_row(4, 4'h0, 4'h0, 1, 1, 2); set_row(5, 4'h0, 4'h0, 0, 0, 0);
    run_table("hp0", 6, -1, '0);
    $display("[TB] hp0 shot done");

    // Mid-FIRE input change and start pulse are ignored.
    delay_flat = {8'd6, 8'd4, 8'd2, 8'd0}; half_period = 4'd2; num_cycles = 4'd1;
    load_staggered();
    run_table("midst", 12, 2, 32'd0);
    set_row(0, 4'hF, 4'h0, 0, 1, 1); set_row(1, 4'hF, 4'h0, 0, 1, 1);
    set_row(2, 4'h0, 4'hF, 0, 1, 1); set_row(3, 4'h0, 4'hF, 0, 1, 1);
    set_row(4, 4'h0, 4'h0, 1, 1, 2); set_row(5, 4'h0, 4'h0, 0, 0, 0);
    run_table("newd", 6, -1, '0);
    $display("[TB] mid-fire start shot done");

    // Reset during the burst.
    delay_flat = {8'd6, 8'd4, 8'd2, 8'd0};
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("mrst_tx", 32'({tx_p, tx_n, tx_en}), 32'd0);
    check("mrst_ctl", 32'({busy, done, rx_start}), 32'd0);
    check("mrst_st", 32'(debug_state), 32'd0);
    reset = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || rx_start) cnt_done++;
    end
    check("mrst_nodone", 32'(cnt_done), 32'd0);
    load_staggered();
    run_table("after", 12, -1, '0);
    $display("[TB] reset mid-burst done");

    // All-max: equal delays 255, hp=15, nc=15 -> 255+450 FIRE cycles.
    delay_flat = 32'hFFFF_FFFF; half_period = 4'd15; num_cycles = 4'd15;
    done_idx = -1; cnt_p = 0; cnt_n = 0; cnt_part = 0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2000 && done_idx < 0; i++) begin
      if (tx_p == 4'hF) cnt_p++;
      if (tx_n == 4'hF) cnt_n++;
      if ((tx_p != 4'h0 && tx_p != 4'hF) || (tx_n != 4'h0 && tx_n != 4'hF)) cnt_part++;
      if (done) done_idx = i;
      else @(negedge clk);
    end
    check("max_done_idx", 32'(done_idx), 32'd705);
    check("max_cnt_p", 32'(cnt_p), 32'd225);
    check("max_cnt_n", 32'(cnt_n), 32'd225);
    check("max_equal", 32'(cnt_part), 32'd0);
    @(negedge clk);
    check("max_idle", 32'({busy, debug_state}), 32'd0);
    $display("[TB] all-max shot done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
